cle_label_packer: RTL

//  Readback/encode end of the CLE label-map interface: reads the 32x32 label map
//  (1024 bytes, one label per pixel) from label SRAM and re-packs it into the
//  128-byte, 8-pixel-per-byte bitmap format of the input image ROM.

---
 rtl/cle_label_packer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cle_label_packer.sv
// ============================================================================
// Module      : cle_label_packer
// Description : Packs the 32x32 label map from label SRAM back into the
//               8-pixel-per-byte image bitmap and streams it over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cle_label_packer #(
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int LABEL_W = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [LABEL_W-1:0]                  sram_q,
  output logic [$clog2(IMG_W*IMG_H)-1:0]      sram_a,
  output logic [7:0]                          bm_d,
  output logic [$clog2(IMG_W*IMG_H)-4:0]      bm_a,
  output logic                                bm_valid,
  input  logic                                bm_ready,
  output logic [$clog2(IMG_W*IMG_H):0]        fg_count,
  output logic [LABEL_W-1:0]                  max_label,
  output logic                                busy,
  output logic                                finish
);

  localparam int c_AW     = $clog2(IMG_W*IMG_H);
  localparam int c_BAW    = c_AW - 3;
  localparam int c_LAST_K = (IMG_W*IMG_H)/8 - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_j;
  logic [c_BAW-1:0]   r_k;
  logic [6:0]         r_shift;
  logic [c_AW-1:0]    r_sram_a;
  logic [7:0]         r_bm_d;
  logic [c_BAW-1:0]   r_bm_a;
  logic               r_bm_valid;
  logic [c_AW:0]      r_fg_count;
  logic [LABEL_W-1:0] r_max_label;

  logic w_bit;
  logic w_handshake;
  logic w_last_k;

  assign w_bit       = (sram_q != '0);
  assign w_handshake = r_bm_valid & bm_ready;
  assign w_last_k    = (r_k == c_BAW'(c_LAST_K));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_READ;
      S_READ: if (r_j == 4'd8) w_state_next = S_SEND;
      S_SEND: if (w_handshake) w_state_next = w_last_k ? S_DONE : S_READ;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Address runs one cycle ahead of the data it returns: the pixel captured
  // at count j belongs to the address issued at count j-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_j         <= 4'd0;
      r_k         <= '0;
      r_shift     <= 7'd0;
      r_sram_a    <= '0;
      r_bm_d      <= 8'd0;
      r_bm_a      <= '0;
      r_bm_valid  <= 1'b0;
      r_fg_count  <= '0;
      r_max_label <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_j         <= 4'd0;
            r_k         <= '0;
            r_sram_a    <= '0;
            r_fg_count  <= '0;
            r_max_label <= '0;
          end
        end
        S_READ: begin
          r_j <= (r_j == 4'd8) ? 4'd0 : r_j + 4'd1;
          if (r_j < 4'd7) begin
            r_sram_a <= r_sram_a + c_AW'(1);
          end
          if (r_j != 4'd0) begin
            r_shift <= {r_shift[5:0], w_bit};
            if (w_bit) r_fg_count <= r_fg_count + (c_AW+1)'(1);
            if (sram_q > r_max_label) r_max_label <= sram_q;
          end
          if (r_j == 4'd8) begin
            r_bm_d     <= {r_shift, w_bit};
            r_bm_a     <= r_k;
            r_bm_valid <= 1'b1;
          end
        end
        S_SEND: begin
          // Address is frozen here so no SRAM reads are issued while stalled.
          if (w_handshake) begin
            r_bm_valid <= 1'b0;
            if (!w_last_k) begin
              r_k      <= r_k + c_BAW'(1);
              r_j      <= 4'd0;
              r_sram_a <= {r_k + c_BAW'(1), 3'b000};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sram_a    = r_sram_a;
  assign bm_d      = r_bm_d;
  assign bm_a      = r_bm_a;
  assign bm_valid  = r_bm_valid;
  assign fg_count  = r_fg_count;
  assign max_label = r_max_label;
  assign busy      = (r_state != S_IDLE);
  assign finish    = (r_state == S_DONE);

endmodule

`default_nettype wire
